// File: rtl/ytydla_cmac_core.sv
// Sequential dot-product engine: one 32x32 MAC per cycle over the first N
// data/weight pairs, with the result registered and held between passes.
module ytydla_cmac_core #(
  parameter int MAX_ELEM = 64,
  parameter int DW       = 32
) (
  input  logic          ytydla_core_clk,
  input  logic          ytydla_core_rst_n,
  input  logic [DW-1:0] mem2cmac_dat_0,
  input  logic [DW-1:0] mem2cmac_dat_1,
  input  logic [DW-1:0] mem2cmac_dat_2,
  input  logic [DW-1:0] mem2cmac_dat_3,
  input  logic [DW-1:0] mem2cmac_dat_4,
  input  logic [DW-1:0] mem2cmac_dat_5,
  input  logic [DW-1:0] mem2cmac_dat_6,
  input  logic [DW-1:0] mem2cmac_dat_7,
  input  logic [DW-1:0] mem2cmac_dat_8,
  input  logic [DW-1:0] mem2cmac_dat_9,
  input  logic [DW-1:0] mem2cmac_dat_10,
  input  logic [DW-1:0] mem2cmac_dat_11,
  input  logic [DW-1:0] mem2cmac_dat_12,
  input  logic [DW-1:0] mem2cmac_dat_13,
  input  logic [DW-1:0] mem2cmac_dat_14,
  input  logic [DW-1:0] mem2cmac_dat_15,
  input  logic [DW-1:0] mem2cmac_dat_16,
  input  logic [DW-1:0] mem2cmac_dat_17,
  input  logic [DW-1:0] mem2cmac_dat_18,
  input  logic [DW-1:0] mem2cmac_dat_19,
  input  logic [DW-1:0] mem2cmac_dat_20,
  input  logic [DW-1:0] mem2cmac_dat_21,
  input  logic [DW-1:0] mem2cmac_dat_22,
  input  logic [DW-1:0] mem2cmac_dat_23,
  input  logic [DW-1:0] mem2cmac_dat_24,
  input  logic [DW-1:0] mem2cmac_dat_25,
  input  logic [DW-1:0] mem2cmac_dat_26,
  input  logic [DW-1:0] mem2cmac_dat_27,
  input  logic [DW-1:0] mem2cmac_dat_28,
  input  logic [DW-1:0] mem2cmac_dat_29,
  input  logic [DW-1:0] mem2cmac_dat_30,
  input  logic [DW-1:0] mem2cmac_dat_31,
  input  logic [DW-1:0] mem2cmac_dat_32,
  input  logic [DW-1:0] mem2cmac_dat_33,
  input  logic [DW-1:0] mem2cmac_dat_34,
  input  logic [DW-1:0] mem2cmac_dat_35,
  input  logic [DW-1:0] mem2cmac_dat_36,
  input  logic [DW-1:0] mem2cmac_dat_37,
  input  logic [DW-1:0] mem2cmac_dat_38,
  input  logic [DW-1:0] mem2cmac_dat_39,
  input  logic [DW-1:0] mem2cmac_dat_40,
  input  logic [DW-1:0] mem2cmac_dat_41,
  input  logic [DW-1:0] mem2cmac_dat_42,
  input  logic [DW-1:0] mem2cmac_dat_43,
  input  logic [DW-1:0] mem2cmac_dat_44,
  input  logic [DW-1:0] mem2cmac_dat_45,
  input  logic [DW-1:0] mem2cmac_dat_46,
  input  logic [DW-1:0] mem2cmac_dat_47,
  input  logic [DW-1:0] mem2cmac_dat_48,
  input  logic [DW-1:0] mem2cmac_dat_49,
  input  logic [DW-1:0] mem2cmac_dat_50,
  input  logic [DW-1:0] mem2cmac_dat_51,
  input  logic [DW-1:0] mem2cmac_dat_52,
  input  logic [DW-1:0] mem2cmac_dat_53,
  input  logic [DW-1:0] mem2cmac_dat_54,
  input  logic [DW-1:0] mem2cmac_dat_55,
  input  logic [DW-1:0] mem2cmac_dat_56,
  input  logic [DW-1:0] mem2cmac_dat_57,
  input  logic [DW-1:0] mem2cmac_dat_58,
  input  logic [DW-1:0] mem2cmac_dat_59,
  input  logic [DW-1:0] mem2cmac_dat_60,
  input  logic [DW-1:0] mem2cmac_dat_61,
  input  logic [DW-1:0] mem2cmac_dat_62,
  input  logic [DW-1:0] mem2cmac_dat_63,
  input  logic [DW-1:0] mem2cmac_dat_size,
  input  logic [DW-1:0] mem2cmac_wt_0,
  input  logic [DW-1:0] mem2cmac_wt_1,
  input  logic [DW-1:0] mem2cmac_wt_2,
  input  logic [DW-1:0] mem2cmac_wt_3,
  input  logic [DW-1:0] mem2cmac_wt_4,
  input  logic [DW-1:0] mem2cmac_wt_5,
  input  logic [DW-1:0] mem2cmac_wt_6,
  input  logic [DW-1:0] mem2cmac_wt_7,
  input  logic [DW-1:0] mem2cmac_wt_8,
  input  logic [DW-1:0] mem2cmac_wt_9,
  input  logic [DW-1:0] mem2cmac_wt_10,
  input  logic [DW-1:0] mem2cmac_wt_11,
  input  logic [DW-1:0] mem2cmac_wt_12,
  input  logic [DW-1:0] mem2cmac_wt_13,
  input  logic [DW-1:0] mem2cmac_wt_14,
  input  logic [DW-1:0] mem2cmac_wt_15,
  input  logic [DW-1:0] mem2cmac_wt_16,
  input  logic [DW-1:0] mem2cmac_wt_17,
  input  logic [DW-1:0] mem2cmac_wt_18,
  input  logic [DW-1:0] mem2cmac_wt_19,
  input  logic [DW-1:0] mem2cmac_wt_20,
  input  logic [DW-1:0] mem2cmac_wt_21,
  input  logic [DW-1:0] mem2cmac_wt_22,
  input  logic [DW-1:0] mem2cmac_wt_23,
  input  logic [DW-1:0] mem2cmac_wt_24,
  input  logic [DW-1:0] mem2cmac_wt_25,
  input  logic [DW-1:0] mem2cmac_wt_26,
  input  logic [DW-1:0] mem2cmac_wt_27,
  input  logic [DW-1:0] mem2cmac_wt_28,
  input  logic [DW-1:0] mem2cmac_wt_29,
  input  logic [DW-1:0] mem2cmac_wt_30,
  input  logic [DW-1:0] mem2cmac_wt_31,
  input  logic [DW-1:0] mem2cmac_wt_32,
  input  logic [DW-1:0] mem2cmac_wt_33,
  input  logic [DW-1:0] mem2cmac_wt_34,
  input  logic [DW-1:0] mem2cmac_wt_35,
  input  logic [DW-1:0] mem2cmac_wt_36,
  input  logic [DW-1:0] mem2cmac_wt_37,
  input  logic [DW-1:0] mem2cmac_wt_38,
  input  logic [DW-1:0] mem2cmac_wt_39,
  input  logic [DW-1:0] mem2cmac_wt_40,
  input  logic [DW-1:0] mem2cmac_wt_41,
  input  logic [DW-1:0] mem2cmac_wt_42,
  input  logic [DW-1:0] mem2cmac_wt_43,
  input  logic [DW-1:0] mem2cmac_wt_44,
  input  logic [DW-1:0] mem2cmac_wt_45,
  input  logic [DW-1:0] mem2cmac_wt_46,
  input  logic [DW-1:0] mem2cmac_wt_47,
  input  logic [DW-1:0] mem2cmac_wt_48,
  input  logic [DW-1:0] mem2cmac_wt_49,
  input  logic [DW-1:0] mem2cmac_wt_50,
  input  logic [DW-1:0] mem2cmac_wt_51,
  input  logic [DW-1:0] mem2cmac_wt_52,
  input  logic [DW-1:0] mem2cmac_wt_53,
  input  logic [DW-1:0] mem2cmac_wt_54,
  input  logic [DW-1:0] mem2cmac_wt_55,
  input  logic [DW-1:0] mem2cmac_wt_56,
  input  logic [DW-1:0] mem2cmac_wt_57,
  input  logic [DW-1:0] mem2cmac_wt_58,
  input  logic [DW-1:0] mem2cmac_wt_59,
  input  logic [DW-1:0] mem2cmac_wt_60,
  input  logic [DW-1:0] mem2cmac_wt_61,
  input  logic [DW-1:0] mem2cmac_wt_62,
  input  logic [DW-1:0] mem2cmac_wt_63,
  output logic [DW-1:0] cmac2mem_result
);

  localparam int IW = 7;

  typedef enum logic [0:0] {
    S_LOAD = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_idx;
  logic [IW-1:0]   r_n;
  logic [DW-1:0]   r_acc;

  logic [DW-1:0]   w_dat [MAX_ELEM];
  logic [DW-1:0]   w_wt  [MAX_ELEM];
  logic [IW-1:0]   w_clamped;
  logic [DW-1:0]   w_dat_sel;
  logic [DW-1:0]   w_wt_sel;
  logic [DW-1:0]   w_prod;
  logic [DW-1:0]   w_sum;
  logic            w_last;

  assign w_dat[0]  = mem2cmac_dat_0;   assign w_wt[0]  = mem2cmac_wt_0;
  assign w_dat[1]  = mem2cmac_dat_1;   assign w_wt[1]  = mem2cmac_wt_1;
  assign w_dat[2]  = mem2cmac_dat_2;   assign w_wt[2]  = mem2cmac_wt_2;
  assign w_dat[3]  = mem2cmac_dat_3;   assign w_wt[3]  = mem2cmac_wt_3;
  assign w_dat[4]  = mem2cmac_dat_4;   assign w_wt[4]  = mem2cmac_wt_4;
  assign w_dat[5]  = mem2cmac_dat_5;   assign w_wt[5]  = mem2cmac_wt_5;
  assign w_dat[6]  = mem2cmac_dat_6;   assign w_wt[6]  = mem2cmac_wt_6;
  assign w_dat[7]  = mem2cmac_dat_7;   assign w_wt[7]  = mem2cmac_wt_7;
  assign w_dat[8]  = mem2cmac_dat_8;   assign w_wt[8]  = mem2cmac_wt_8;
  assign w_dat[9]  = mem2cmac_dat_9;   assign w_wt[9]  = mem2cmac_wt_9;
  assign w_dat[10] = mem2cmac_dat_10;  assign w_wt[10] = mem2cmac_wt_10;
  assign w_dat[11] = mem2cmac_dat_11;  assign w_wt[11] = mem2cmac_wt_11;
  assign w_dat[12] = mem2cmac_dat_12;  assign w_wt[12] = mem2cmac_wt_12;
  assign w_dat[13] = mem2cmac_dat_13;  assign w_wt[13] = mem2cmac_wt_13;
  assign w_dat[14] = mem2cmac_dat_14;  assign w_wt[14] = mem2cmac_wt_14;
  assign w_dat[15] = mem2cmac_dat_15;  assign w_wt[15] = mem2cmac_wt_15;
  assign w_dat[16] = mem2cmac_dat_16;  assign w_wt[16] = mem2cmac_wt_16;
  assign w_dat[17] = mem2cmac_dat_17;  assign w_wt[17] = mem2cmac_wt_17;
  assign w_dat[18] = mem2cmac_dat_18;  assign w_wt[18] = mem2cmac_wt_18;
  assign w_dat[19] = mem2cmac_dat_19;  assign w_wt[19] = mem2cmac_wt_19;
  assign w_dat[20] = mem2cmac_dat_20;  assign w_wt[20] = mem2cmac_wt_20;
  assign w_dat[21] = mem2cmac_dat_21;  assign w_wt[21] = mem2cmac_wt_21;
  assign w_dat[22] = mem2cmac_dat_22;  assign w_wt[22] = mem2cmac_wt_22;
  assign w_dat[23] = mem2cmac_dat_23;  assign w_wt[23] = mem2cmac_wt_23;
  assign w_dat[24] = mem2cmac_dat_24;  assign w_wt[24] = mem2cmac_wt_24;
  assign w_dat[25] = mem2cmac_dat_25;  assign w_wt[25] = mem2cmac_wt_25;
  assign w_dat[26] = mem2cmac_dat_26;  assign w_wt[26] = mem2cmac_wt_26;
  assign w_dat[27] = mem2cmac_dat_27;  assign w_wt[27] = mem2cmac_wt_27;
  assign w_dat[28] = mem2cmac_dat_28;  assign w_wt[28] = mem2cmac_wt_28;
  assign w_dat[29] = mem2cmac_dat_29;  assign w_wt[29] = mem2cmac_wt_29;
  assign w_dat[30] = mem2cmac_dat_30;  assign w_wt[30] = mem2cmac_wt_30;
  assign w_dat[31] = mem2cmac_dat_31;  assign w_wt[31] = mem2cmac_wt_31;
  assign w_dat[32] = mem2cmac_dat_32;  assign w_wt[32] = mem2cmac_wt_32;
  assign w_dat[33] = mem2cmac_dat_33;  assign w_wt[33] = mem2cmac_wt_33;
  assign w_dat[34] = mem2cmac_dat_34;  assign w_wt[34] = mem2cmac_wt_34;
  assign w_dat[35] = mem2cmac_dat_35;  assign w_wt[35] = mem2cmac_wt_35;
  assign w_dat[36] = mem2cmac_dat_36;  assign w_wt[36] = mem2cmac_wt_36;
  assign w_dat[37] = mem2cmac_dat_37;  assign w_wt[37] = mem2cmac_wt_37;
  assign w_dat[38] = mem2cmac_dat_38;  assign w_wt[38] = mem2cmac_wt_38;
  assign w_dat[39] = mem2cmac_dat_39;  assign w_wt[39] = mem2cmac_wt_39;
  assign w_dat[40] = mem2cmac_dat_40;  assign w_wt[40] = mem2cmac_wt_40;
  assign w_dat[41] = mem2cmac_dat_41;  assign w_wt[41] = mem2cmac_wt_41;
  assign w_dat[42] = mem2cmac_dat_42;  assign w_wt[42] = mem2cmac_wt_42;
  assign w_dat[43] = mem2cmac_dat_43;  assign w_wt[43] = mem2cmac_wt_43;
  assign w_dat[44] = mem2cmac_dat_44;  assign w_wt[44] = mem2cmac_wt_44;
  assign w_dat[45] = mem2cmac_dat_45;  assign w_wt[45] = mem2cmac_wt_45;
  assign w_dat[46] = mem2cmac_dat_46;  assign w_wt[46] = mem2cmac_wt_46;
  assign w_dat[47] = mem2cmac_dat_47;  assign w_wt[47] = mem2cmac_wt_47;
  assign w_dat[48] = mem2cmac_dat_48;  assign w_wt[48] = mem2cmac_wt_48;
  assign w_dat[49] = mem2cmac_dat_49;  assign w_wt[49] = mem2cmac_wt_49;
  assign w_dat[50] = mem2cmac_dat_50;  assign w_wt[50] = mem2cmac_wt_50;
  assign w_dat[51] = mem2cmac_dat_51;  assign w_wt[51] = mem2cmac_wt_51;
  assign w_dat[52] = mem2cmac_dat_52;  assign w_wt[52] = mem2cmac_wt_52;
  assign w_dat[53] = mem2cmac_dat_53;  assign w_wt[53] = mem2cmac_wt_53;
  assign w_dat[54] = mem2cmac_dat_54;  assign w_wt[54] = mem2cmac_wt_54;
  assign w_dat[55] = mem2cmac_dat_55;  assign w_wt[55] = mem2cmac_wt_55;
  assign w_dat[56] = mem2cmac_dat_56;  assign w_wt[56] = mem2cmac_wt_56;
  assign w_dat[57] = mem2cmac_dat_57;  assign w_wt[57] = mem2cmac_wt_57;
  assign w_dat[58] = mem2cmac_dat_58;  assign w_wt[58] = mem2cmac_wt_58;
  assign w_dat[59] = mem2cmac_dat_59;  assign w_wt[59] = mem2cmac_wt_59;
  assign w_dat[60] = mem2cmac_dat_60;  assign w_wt[60] = mem2cmac_wt_60;
  assign w_dat[61] = mem2cmac_dat_61;  assign w_wt[61] = mem2cmac_wt_61;
  assign w_dat[62] = mem2cmac_dat_62;  assign w_wt[62] = mem2cmac_wt_62;
  assign w_dat[63] = mem2cmac_dat_63;  assign w_wt[63] = mem2cmac_wt_63;

  assign w_clamped = (mem2cmac_dat_size > DW'(MAX_ELEM)) ? IW'(MAX_ELEM)
                                                         : mem2cmac_dat_size[IW-1:0];

  // In RUN r_idx < r_n, so only in-range operands ever reach the accumulator.
  assign w_dat_sel = w_dat[r_idx[IW-2:0]];
  assign w_wt_sel  = w_wt[r_idx[IW-2:0]];
  assign w_prod    = w_dat_sel * w_wt_sel;
  assign w_sum     = r_acc + w_prod;
  assign w_last    = (r_idx == (r_n - IW'(1)));

  always_ff @(posedge ytydla_core_clk or negedge ytydla_core_rst_n) begin
    if (!ytydla_core_rst_n) begin
      r_state         <= S_LOAD;
      r_idx           <= '0;
      r_n             <= '0;
      r_acc           <= '0;
      cmac2mem_result <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          r_n   <= w_clamped;
          r_idx <= '0;
          r_acc <= '0;
          if (w_clamped != '0) begin
            r_state <= S_RUN;
          end else begin
            cmac2mem_result <= '0;
          end
        end
        S_RUN: begin
          if (w_last) begin
            // Wrap idx to 0 so it never counts past the last valid element.
            cmac2mem_result <= w_sum;
            r_acc           <= w_sum;
            r_idx           <= '0;
            r_state         <= S_LOAD;
          end else begin
            r_acc <= w_sum;
            r_idx <= r_idx + IW'(1);
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_ytydla_cmac_core.sv
// Directed bench for the CMAC core: reset, identity sum, wrap, clamp,
// size zero, back-to-back passes and asynchronous reset mid-pass.
module tb_ytydla_cmac_core;

  logic        clk;
  logic        rst_n;
  logic [31:0] dat [64];
  logic [31:0] wt  [64];
  logic [31:0] size;
  logic [31:0] result;

  int n_checks = 0;
  int n_errors = 0;

  ytydla_cmac_core dut (
    .ytydla_core_clk(clk), .ytydla_core_rst_n(rst_n),
    .mem2cmac_dat_size(size), .cmac2mem_result(result),
    .mem2cmac_dat_0(dat[0]),   .mem2cmac_dat_1(dat[1]),   .mem2cmac_dat_2(dat[2]),   .mem2cmac_dat_3(dat[3]),
    .mem2cmac_dat_4(dat[4]),   .mem2cmac_dat_5(dat[5]),   .mem2cmac_dat_6(dat[6]),   .mem2cmac_dat_7(dat[7]),
    .mem2cmac_dat_8(dat[8]),   .mem2cmac_dat_9(dat[9]),   .mem2cmac_dat_10(dat[10]), .mem2cmac_dat_11(dat[11]),
    .mem2cmac_dat_12(dat[12]), .mem2cmac_dat_13(dat[13]), .mem2cmac_dat_14(dat[14]), .mem2cmac_dat_15(dat[15]),
    .mem2cmac_dat_16(dat[16]), .mem2cmac_dat_17(dat[17]), .mem2cmac_dat_18(dat[18]), .mem2cmac_dat_19(dat[19]),
    .mem2cmac_dat_20(dat[20]), .mem2cmac_dat_21(dat[21]), .mem2cmac_dat_22(dat[22]), .mem2cmac_dat_23(dat[23]),
    .mem2cmac_dat_24(dat[24]), .mem2cmac_dat_25(dat[25]), .mem2cmac_dat_26(dat[26]), .mem2cmac_dat_27(dat[27]),
    .mem2cmac_dat_28(dat[28]), .mem2cmac_dat_29(dat[29]), .mem2cmac_dat_30(dat[30]), .mem2cmac_dat_31(dat[31]),
    .mem2cmac_dat_32(dat[32]), .mem2cmac_dat_33(dat[33]), .mem2cmac_dat_34(dat[34]), .mem2cmac_dat_35(dat[35]),
    .mem2cmac_dat_36(dat[36]), .mem2cmac_dat_37(dat[37]), .mem2cmac_dat_38(dat[38]), .mem2cmac_dat_39(dat[39]),
    .mem2cmac_dat_40(dat[40]), .mem2cmac_dat_41(dat[41]), .mem2cmac_dat_42(dat[42]), .mem2cmac_dat_43(dat[43]),
    .mem2cmac_dat_44(dat[44]), .mem2cmac_dat_45(dat[45]), .mem2cmac_dat_46(dat[46]), .mem2cmac_dat_47(dat[47]),
    .mem2cmac_dat_48(dat[48]), .mem2cmac_dat_49(dat[49]), .mem2cmac_dat_50(dat[50]), .mem2cmac_dat_51(dat[51]),
    .mem2cmac_dat_52(dat[52]), .mem2cmac_dat_53(dat[53]), .mem2cmac_dat_54(dat[54]), .mem2cmac_dat_55(dat[55]),
    .mem2cmac_dat_56(dat[56]), .mem2cmac_dat_57(dat[57]), .mem2cmac_dat_58(dat[58]), .mem2cmac_dat_59(dat[59]),
    .mem2cmac_dat_60(dat[60]), .mem2cmac_dat_61(dat[61]), .mem2cmac_dat_62(dat[62]), .mem2cmac_dat_63(dat[63]),
    .mem2cmac_wt_0(wt[0]),   .mem2cmac_wt_1(wt[1]),   .mem2cmac_wt_2(wt[2]),   .mem2cmac_wt_3(wt[3]),
    .mem2cmac_wt_4(wt[4]),   .mem2cmac_wt_5(wt[5]),   .mem2cmac_wt_6(wt[6]),   .mem2cmac_wt_7(wt[7]),
    .mem2cmac_wt_8(wt[8]),   .mem2cmac_wt_9(wt[9]),   .mem2cmac_wt_10(wt[10]), .mem2cmac_wt_11(wt[11]),
    .mem2cmac_wt_12(wt[12]), .mem2cmac_wt_13(wt[13]), .mem2cmac_wt_14(wt[14]), .mem2cmac_wt_15(wt[15]),
    .mem2cmac_wt_16(wt[16]), .mem2cmac_wt_17(wt[17]), .mem2cmac_wt_18(wt[18]), .mem2cmac_wt_19(wt[19]),
    .mem2cmac_wt_20(wt[20]), .mem2cmac_wt_21(wt[21]), .mem2cmac_wt_22(wt[22]), .mem2cmac_wt_23(wt[23]),
    .mem2cmac_wt_24(wt[24]), .mem2cmac_wt_25(wt[25]), .mem2cmac_wt_26(wt[26]), .mem2cmac_wt_27(wt[27]),
    .mem2cmac_wt_28(wt[28]), .mem2cmac_wt_29(wt[29]), .mem2cmac_wt_30(wt[30]), .mem2cmac_wt_31(wt[31]),
    .mem2cmac_wt_32(wt[32]), .mem2cmac_wt_33(wt[33]), .mem2cmac_wt_34(wt[34]), .mem2cmac_wt_35(wt[35]),
    .mem2cmac_wt_36(wt[36]), .mem2cmac_wt_37(wt[37]), .mem2cmac_wt_38(wt[38]), .mem2cmac_wt_39(wt[39]),
    .mem2cmac_wt_40(wt[40]), .mem2cmac_wt_41(wt[41]), .mem2cmac_wt_42(wt[42]), .mem2cmac_wt_43(wt[43]),
    .mem2cmac_wt_44(wt[44]), .mem2cmac_wt_45(wt[45]), .mem2cmac_wt_46(wt[46]), .mem2cmac_wt_47(wt[47]),
    .mem2cmac_wt_48(wt[48]), .mem2cmac_wt_49(wt[49]), .mem2cmac_wt_50(wt[50]), .mem2cmac_wt_51(wt[51]),
    .mem2cmac_wt_52(wt[52]), .mem2cmac_wt_53(wt[53]), .mem2cmac_wt_54(wt[54]), .mem2cmac_wt_55(wt[55]),
    .mem2cmac_wt_56(wt[56]), .mem2cmac_wt_57(wt[57]), .mem2cmac_wt_58(wt[58]), .mem2cmac_wt_59(wt[59]),
    .mem2cmac_wt_60(wt[60]), .mem2cmac_wt_61(wt[61]), .mem2cmac_wt_62(wt[62]), .mem2cmac_wt_63(wt[63])
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 64; k++) begin
      dat[k] = 'x;
      wt[k]  = 'x;
    end
  endtask

  task automatic load_identity25();
    clear_inputs();
    size = 32'd25;
    for (int k = 0; k < 25; k++) begin
      dat[k] = 32'(k + 1);
      wt[k]  = 32'd1;
    end
  endtask

  // Assert reset across two edges, then release just after an edge so the
  // next rising edge is edge 1 after release.
  task automatic apply_reset();
    rst_n = 1'b0;
    tick(2);
    check_eq("reset_hold", result, 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    size  = 32'd0;
    clear_inputs();

    // Reset and N=25 identity sum: 1+2+...+25 = 325 on edge 26.
    load_identity25();
    tick(1);
    check_eq("reset_first", result, 32'd0);
    apply_reset();
    tick(25);
    check_eq("id25_edge25", result, 32'd0);
    tick(1);
    check_eq("id25_edge26", result, 32'd325);
    for (int e = 27; e <= 50; e++) begin
      tick(1);
      check_eq("id25_hold", result, 32'd325);
    end

    // Wrap: 0xFFFFFFFF*3 + 2*2 = 3*2^32 + 1 -> 1.
    clear_inputs();
    size = 32'd2;
    dat[0] = 32'hFFFF_FFFF; wt[0] = 32'd3;
    dat[1] = 32'd2;         wt[1] = 32'd2;
    apply_reset();
    tick(2);
    check_eq("wrap2_pre", result, 32'd0);
    tick(1);
    check_eq("wrap2", result, 32'h0000_0001);
    // Next LOAD picks up N=1: 0x80000000*2 wraps to 0.
    size = 32'd1;
    dat[0] = 32'h8000_0000; wt[0] = 32'd2;
    dat[1] = 'x;            wt[1] = 'x;
    tick(1);
    check_eq("wrap1_hold", result, 32'h0000_0001);
    tick(1);
    check_eq("wrap1", result, 32'd0);

    // Clamp: N=100 uses 64 elements of 2*3 -> 384 after 65 edges.
    size = 32'd100;
    for (int k = 0; k < 64; k++) begin
      dat[k] = 32'd2;
      wt[k]  = 32'd3;
    end
    apply_reset();
    tick(64);
    check_eq("clamp_edge64", result, 32'd0);
    tick(1);
    check_eq("clamp_edge65", result, 32'd384);
    // Size zero: the next LOAD clears the output in a single edge.
    size = 32'd0;
    tick(1);
    check_eq("size_zero", result, 32'd0);
    tick(3);
    check_eq("size_zero_hold", result, 32'd0);

    // Back-to-back: N=4, dat_k=wt_k=k -> 0+1+4+9 = 14, then wt=2 -> 12.
    clear_inputs();
    size = 32'd4;
    for (int k = 0; k < 4; k++) begin
      dat[k] = 32'(k);
      wt[k]  = 32'(k);
    end
    apply_reset();
    tick(5);
    check_eq("b2b_first", result, 32'd14);
    for (int k = 0; k < 4; k++) wt[k] = 32'd2;
    for (int e = 0; e < 4; e++) begin
      tick(1);
      check_eq("b2b_hold", result, 32'd14);
    end
    tick(1);
    check_eq("b2b_second", result, 32'd12);

    // Reset mid-pass: output drops to 0 without a clock edge.
    load_identity25();
    apply_reset();
    tick(26);
    check_eq("mid_first", result, 32'd325);
    tick(10);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mid_async_clear", result, 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(25);
    check_eq("mid_edge25", result, 32'd0);
    tick(1);
    check_eq("mid_edge26", result, 32'd325);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
